// File: rtl/mem_stage_if.sv
// Data-memory request/response bus driven by the MEM stage.
interface mem_stage_if;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic        dmem_resp;

   modport master (
      output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      input  dmem_resp
   );

   modport slave (
      input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      output dmem_resp
   );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: aligns load/store requests onto dmem, tracks the
// single outstanding access and registers the MEM/WB payload.
package mem_pkg;
   typedef struct packed {
      logic [4:0] rd_s;
      logic       we_s;
      logic [1:0] sel_s;
   } wb_ctrl_t;

   typedef struct packed {
      logic        valid_s;
      logic [31:0] pc_s;
      logic [31:0] inst_s;
      logic [31:0] alu_out_s;
      logic [31:0] rs2_v_s;
      logic [2:0]  funct3_s;
      logic        mem_rd_s;
      logic        mem_wr_s;
      wb_ctrl_t    wb_ctrl_s;
   } ex_mem_stage_reg_t;

   typedef struct packed {
      logic        valid_s;
      logic [31:0] pc_s;
      logic [31:0] inst_s;
      logic [31:0] alu_out_s;
      logic [2:0]  funct3_s;
      wb_ctrl_t    wb_ctrl_s;
      logic [31:0] mem_addr_s;
      logic [3:0]  mem_rmask_s;
      logic [3:0]  mem_wmask_s;
      logic [31:0] mem_wdata_s;
   } mem_wb_stage_reg_t;
endpackage

module mem_stage
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              move,
   input  ex_mem_stage_reg_t ex_mem_reg,
   mem_stage_if.master       dmem,
   output logic              mem_stall,
   output mem_wb_stage_reg_t mem_wb_reg
);
   typedef enum logic {IDLE, PENDING} state_e;

   state_e            state_q, state_d;
   mem_wb_stage_reg_t mem_wb_q, mem_wb_d;
   logic [1:0]        a;
   logic [3:0]        mask, rmask, wmask;
   logic [31:0]       wdata_sh, wdata;
   logic              misal, issue;

   assign a = ex_mem_reg.alu_out_s[1:0];

   // funct3[1:0] encodes access size; sign bit only matters in WB
   always_comb begin
      mask     = 4'b0000;
      wdata_sh = ex_mem_reg.rs2_v_s;
      misal    = 1'b0;
      unique case (1'b1)
         (ex_mem_reg.funct3_s[1:0] == 2'b00): begin
            mask     = 4'b0001 << a;
            wdata_sh = ex_mem_reg.rs2_v_s << {a, 3'b000};
         end
         (ex_mem_reg.funct3_s[1:0] == 2'b01): begin
            mask     = 4'b0011 << {a[1], 1'b0};
            wdata_sh = ex_mem_reg.rs2_v_s << {a[1], 4'b0000};
            misal    = a[0];
         end
         default: begin
            mask  = 4'b1111;
            misal = (a != 2'b00);
         end
      endcase
   end

   assign issue = !rst && move && ex_mem_reg.valid_s && !misal
                  && (ex_mem_reg.mem_rd_s || ex_mem_reg.mem_wr_s);

   assign rmask = (issue && ex_mem_reg.mem_rd_s) ? mask : 4'b0000;
   assign wmask = (issue && !ex_mem_reg.mem_rd_s) ? mask : 4'b0000;
   assign wdata = (wmask != 4'b0000) ? wdata_sh : 32'h0;

   assign dmem.dmem_addr  = issue ? {ex_mem_reg.alu_out_s[31:2], 2'b00}
                                  : 32'h0;
   assign dmem.dmem_rmask = rmask;
   assign dmem.dmem_wmask = wmask;
   assign dmem.dmem_wdata = wdata;

   assign mem_stall  = !rst && (state_q == PENDING) && !dmem.dmem_resp;
   assign mem_wb_reg = mem_wb_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (issue) state_d = PENDING;
         PENDING: if (dmem.dmem_resp && !issue) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_wb_d = mem_wb_q;
      if (move) begin
         mem_wb_d.valid_s     = ex_mem_reg.valid_s;
         mem_wb_d.pc_s        = ex_mem_reg.pc_s;
         mem_wb_d.inst_s      = ex_mem_reg.inst_s;
         mem_wb_d.alu_out_s   = ex_mem_reg.alu_out_s;
         mem_wb_d.funct3_s    = ex_mem_reg.funct3_s;
         mem_wb_d.wb_ctrl_s   = ex_mem_reg.wb_ctrl_s;
         mem_wb_d.mem_addr_s  = ex_mem_reg.alu_out_s;
         mem_wb_d.mem_rmask_s = rmask;
         mem_wb_d.mem_wmask_s = wmask;
         mem_wb_d.mem_wdata_s = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_wb_q <= '0;
      end else begin
         state_q  <= state_d;
         mem_wb_q <= mem_wb_d;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, directed corner sequences
// and randomized traffic against a byte-lane reference model.
module tb_mem_stage;
   import mem_pkg::*;

   typedef struct {
      logic [2:0]  f3;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [3:0]  rm;
      logic [3:0]  wm;
      logic [31:0] wd;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              move;
   ex_mem_stage_reg_t exm;
   mem_wb_stage_reg_t mwb;
   logic              stall;
   int                checks = 0;
   int                errors = 0;

   mem_stage_if dbus();

   mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .move       (move),
      .ex_mem_reg (exm),
      .dmem       (dbus),
      .mem_stall  (stall),
      .mem_wb_reg (mwb)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drive(logic v, logic [2:0] f3, logic rd, logic wr,
                        logic [31:0] a, logic [31:0] d);
      exm = '0;
      exm.valid_s   = v;
      exm.pc_s      = 32'h0000_0100;
      exm.inst_s    = 32'h0000_0013;
      exm.alu_out_s = a;
      exm.rs2_v_s   = d;
      exm.funct3_s  = f3;
      exm.mem_rd_s  = rd;
      exm.mem_wr_s  = wr;
      exm.wb_ctrl_s.rd_s = 5'd7;
   endtask

   // Reference: an access of N bytes must sit on an N-byte boundary
   // and occupies lanes [off, off+N) of the word.
   function automatic void model(logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] rs2, output logic ok,
                                 output logic [3:0] m,
                                 output logic [31:0] wd);
      int nb;
      int off;
      nb  = 1 << f3[1:0];
      off = int'(addr % 4);
      ok  = (addr % nb) == 0;
      m   = 4'(((1 << nb) - 1) << off);
      wd  = rs2 << (8 * off);
   endfunction

   task automatic run_vec(vec_t v);
      logic issued;
      issued = (v.rm | v.wm) != 4'b0000;
      move = 1'b1;
      dbus.dmem_resp = 1'b0;
      drive(1'b1, v.f3, v.rd, v.wr, v.addr, v.rs2);
      settle();
      chk("vec_rmask", 32'(dbus.dmem_rmask), 32'(v.rm));
      chk("vec_wmask", 32'(dbus.dmem_wmask), 32'(v.wm));
      if (v.wm != 4'b0000) chk("vec_wdata", dbus.dmem_wdata, v.wd);
      if (issued) chk("vec_addr", dbus.dmem_addr, {v.addr[31:2], 2'b00});
      tick();
      chk("vec_wb_valid", 32'(mwb.valid_s), 32'd1);
      chk("vec_wb_rmask", 32'(mwb.mem_rmask_s), 32'(v.rm));
      chk("vec_wb_addr", mwb.mem_addr_s, v.addr);
      move = 1'b0;
      exm.valid_s = 1'b0;
      settle();
      chk("vec_stall", 32'(stall), 32'(issued));
      if (issued) begin
         dbus.dmem_resp = 1'b1;
         #1;
         chk("vec_resp_stall", 32'(stall), 32'd0);
         tick();
         dbus.dmem_resp = 1'b0;
      end else begin
         tick();
      end
   endtask

   vec_t vt[10];

   initial begin
      logic        pend;
      logic        ew_valid;
      logic [31:0] ew_addr;
      logic [3:0]  ew_rm, ew_wm;

      vt[0] = '{3'b000, 1'b1, 1'b0, 32'h1003, 32'h0,        4'b1000, 4'b0000, 32'h0};
      vt[1] = '{3'b001, 1'b0, 1'b1, 32'h2002, 32'h0000BEEF, 4'b0000, 4'b1100, 32'hBEEF0000};
      vt[2] = '{3'b010, 1'b1, 1'b0, 32'h4001, 32'h0,        4'b0000, 4'b0000, 32'h0};
      vt[3] = '{3'b000, 1'b0, 1'b1, 32'h0101, 32'h12345678, 4'b0000, 4'b0010, 32'h34567800};
      vt[4] = '{3'b101, 1'b1, 1'b0, 32'h0202, 32'h0,        4'b1100, 4'b0000, 32'h0};
      vt[5] = '{3'b010, 1'b0, 1'b1, 32'h0300, 32'hDEADBEEF, 4'b0000, 4'b1111, 32'hDEADBEEF};
      vt[6] = '{3'b010, 1'b0, 1'b1, 32'h0302, 32'hDEADBEEF, 4'b0000, 4'b0000, 32'h0};
      vt[7] = '{3'b001, 1'b1, 1'b0, 32'h0401, 32'h0,        4'b0000, 4'b0000, 32'h0};
      vt[8] = '{3'b100, 1'b1, 1'b0, 32'h0502, 32'h0,        4'b0100, 4'b0000, 32'h0};
      vt[9] = '{3'b001, 1'b0, 1'b1, 32'h0600, 32'hCAFEBABE, 4'b0000, 4'b0011, 32'hCAFEBABE};

      // reset held two cycles with a live request presented
      rst = 1'b1;
      move = 1'b1;
      dbus.dmem_resp = 1'b0;
      drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h10, 32'h0);
      for (int k = 0; k < 2; k++) begin
         tick();
         settle();
         chk("rst_rmask", 32'(dbus.dmem_rmask), 32'd0);
         chk("rst_wmask", 32'(dbus.dmem_wmask), 32'd0);
         chk("rst_addr", dbus.dmem_addr, 32'h0);
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_valid", 32'(mwb.valid_s), 32'd0);
      end
      tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vt[i]);

      // lb with response three cycles late
      move = 1'b1;
      drive(1'b1, 3'b000, 1'b1, 1'b0, 32'h1003, 32'h0);
      settle();
      chk("lb_rmask", 32'(dbus.dmem_rmask), 32'h8);
      chk("lb_addr", dbus.dmem_addr, 32'h1000);
      tick();
      move = 1'b0;
      exm.valid_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("lb_stall", 32'(stall), 32'd1);
         chk("lb_wb_hold", mwb.mem_addr_s, 32'h1003);
         tick();
      end
      dbus.dmem_resp = 1'b1;
      settle();
      chk("lb_resp_stall", 32'(stall), 32'd0);
      tick();
      dbus.dmem_resp = 1'b0;
      settle();
      chk("lb_idle_stall", 32'(stall), 32'd0);
      tick();

      // back-to-back lw: response and next issue in one cycle
      move = 1'b1;
      drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h3000, 32'h0);
      settle();
      chk("b2b_rmask0", 32'(dbus.dmem_rmask), 32'hF);
      tick();
      dbus.dmem_resp = 1'b1;
      drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h3004, 32'h0);
      settle();
      chk("b2b_stall", 32'(stall), 32'd0);
      chk("b2b_addr1", dbus.dmem_addr, 32'h3004);
      chk("b2b_rmask1", 32'(dbus.dmem_rmask), 32'hF);
      tick();
      chk("b2b_wb_addr", mwb.mem_addr_s, 32'h3004);
      dbus.dmem_resp = 1'b0;
      move = 1'b0;
      exm.valid_s = 1'b0;
      settle();
      chk("b2b_pending", 32'(stall), 32'd1);
      dbus.dmem_resp = 1'b1;
      #1;
      chk("b2b_resp2", 32'(stall), 32'd0);
      tick();
      dbus.dmem_resp = 1'b0;

      // reset while pending, then a stray response
      move = 1'b1;
      drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h5000, 32'h0);
      settle();
      tick();
      move = 1'b0;
      exm.valid_s = 1'b0;
      settle();
      chk("rp_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("rp_rst_stall", 32'(stall), 32'd0);
      tick();
      rst = 1'b0;
      dbus.dmem_resp = 1'b1;
      settle();
      chk("rp_late_stall", 32'(stall), 32'd0);
      chk("rp_wb_valid", 32'(mwb.valid_s), 32'd0);
      tick();
      dbus.dmem_resp = 1'b0;
      settle();
      chk("rp_idle_stall", 32'(stall), 32'd0);
      tick();
      move = 1'b1;
      drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h5004, 32'h0);
      settle();
      tick();
      move = 1'b0;
      exm.valid_s = 1'b0;
      settle();
      chk("rp_new_stall", 32'(stall), 32'd1);
      dbus.dmem_resp = 1'b1;
      tick();
      dbus.dmem_resp = 1'b0;

      // randomized traffic against the model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pend = 1'b0;
      ew_valid = 1'b0;
      ew_addr = 32'h0;
      ew_rm = 4'b0;
      ew_wm = 4'b0;
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  f3;
         logic        rd, wr, v, mv, rs, ok, iss;
         logic [31:0] a, d, wd;
         logic [3:0]  m, erm, ewm;
         int          kind, sel;
         kind = $urandom_range(0, 2);
         rd = (kind == 1);
         wr = (kind == 2);
         sel = $urandom_range(0, 4);
         if (rd) f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
         else    f3 = 3'($urandom_range(0, 2));
         a = $urandom;
         d = $urandom;
         v = ($urandom_range(0, 3) != 0);
         if (pend) begin
            rs = ($urandom_range(0, 2) == 0);
            mv = rs;
         end else begin
            rs = ($urandom_range(0, 4) == 0);
            mv = ($urandom_range(0, 3) != 0);
         end
         move = mv;
         dbus.dmem_resp = rs;
         drive(v, f3, rd, wr, a, d);
         settle();
         model(f3, a, d, ok, m, wd);
         iss = mv && v && (rd || wr) && ok;
         erm = (iss && rd) ? m : 4'b0000;
         ewm = (iss && wr) ? m : 4'b0000;
         chk("rnd_rmask", 32'(dbus.dmem_rmask), 32'(erm));
         chk("rnd_wmask", 32'(dbus.dmem_wmask), 32'(ewm));
         chk("rnd_stall", 32'(stall), 32'(pend && !rs));
         if (ewm != 4'b0000) chk("rnd_wdata", dbus.dmem_wdata, wd);
         if (iss) chk("rnd_addr", dbus.dmem_addr, {a[31:2], 2'b00});
         if (mv) begin
            ew_valid = v;
            ew_addr = a;
            ew_rm = erm;
            ew_wm = ewm;
         end
         if (iss) pend = 1'b1;
         else if (rs) pend = 1'b0;
         tick();
         chk("rnd_wb_valid", 32'(mwb.valid_s), 32'(ew_valid));
         chk("rnd_wb_addr", mwb.mem_addr_s, ew_addr);
         chk("rnd_wb_rmask", 32'(mwb.mem_rmask_s), 32'(ew_rm));
         chk("rnd_wb_wmask", 32'(mwb.mem_wmask_s), 32'(ew_wm));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
